// File: rtl/fp_addsub_ctrl.sv
// Purpose: IEEE-754 binary32 ADD/SUB sequencer driving a shared 27-bit sign-magnitude mantissa ALU.
// Latency: 6+k edges (k = normalize shifts), 1 for special/zero/unsupported operands, 4 for an exact-zero sum.
// Backpressure: start is sampled only while idle; requests arriving while busy are dropped, not queued.
module fp_addsub_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] fp_a,
  input  logic [31:0] fp_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] fp_result,
  output logic [3:0]  flags,
  output logic        alu_en,
  output logic [26:0] alu_a,
  output logic [26:0] alu_b,
  output logic        alu_sign_a,
  output logic        alu_sign_b,
  output logic [1:0]  alu_op,
  input  logic [26:0] alu_result,
  input  logic        alu_carry,
  input  logic        alu_sign
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ALIGN  = 3'd2,
    S_EXEC   = 3'd3,
    S_WAIT   = 3'd4,
    S_NORM   = 3'd5,
    S_ROUND  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  localparam logic [1:0] OP_SUB = 2'b01;

  // flag bit positions inside {invalid, overflow, underflow, unsupported}
  localparam logic [3:0] FLG_INVALID     = 4'b1000;
  localparam logic [3:0] FLG_OVERFLOW    = 4'b0100;
  localparam logic [3:0] FLG_UNDERFLOW   = 4'b0010;
  localparam logic [3:0] FLG_UNSUPPORTED = 4'b0001;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t      state;

  // latched request
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  op_q;

  // unpacked operands (b sign already inverted for SUB)
  logic        sa;
  logic        sb;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [26:0] ma;
  logic [26:0] mb;

  // working result; exp is wide so carry/round overflow past 254 is visible
  logic [9:0]  exp_w;
  logic [26:0] mant;
  logic        sign_r;

  // ---------------- unpack decode ----------------
  logic [7:0]  ua_exp;
  logic [7:0]  ub_exp;
  logic [22:0] ua_frac;
  logic [22:0] ub_frac;
  logic        ua_sign;
  logic        ub_sign;
  logic        ua_zero;
  logic        ub_zero;
  logic        ua_inf;
  logic        ub_inf;
  logic        ua_nan;
  logic        ub_nan;

  // field extraction and class detection of the latched operands
  always_comb begin
    ua_exp  = a_q[30:23];
    ub_exp  = b_q[30:23];
    ua_frac = a_q[22:0];
    ub_frac = b_q[22:0];
    ua_sign = a_q[31];
    ub_sign = b_q[31] ^ (op_q == OP_SUB);
    // denormals are flushed: any exp==0 operand counts as zero
    ua_zero = (ua_exp == 8'd0);
    ub_zero = (ub_exp == 8'd0);
    ua_inf  = (ua_exp == 8'hFF) && (ua_frac == 23'd0);
    ub_inf  = (ub_exp == 8'hFF) && (ub_frac == 23'd0);
    ua_nan  = (ua_exp == 8'hFF) && (ua_frac != 23'd0);
    ub_nan  = (ub_exp == 8'hFF) && (ub_frac != 23'd0);
  end

  // ---------------- alignment ----------------
  logic        a_big;
  logic [7:0]  exp_diff;
  logic [7:0]  exp_max;
  logic [26:0] small_m;
  logic [26:0] shift_mask;
  logic [26:0] aligned_m;
  logic [4:0]  shamt;

  // single barrel shift of the smaller-exponent mantissa, lost bits folded into sticky
  always_comb begin
    a_big      = (ea >= eb);
    exp_diff   = a_big ? (ea - eb) : (eb - ea);
    exp_max    = a_big ? ea : eb;
    small_m    = a_big ? mb : ma;
    shamt      = exp_diff[4:0];
    shift_mask = 27'd0;
    aligned_m  = small_m;
    if (exp_diff >= 8'd26) begin
      // hidden bit falls below S: only the sticky survives
      aligned_m = 27'd1;
    end else begin
      shift_mask = (27'd1 << shamt) - 27'd1;
      aligned_m  = (small_m >> shamt) | {26'd0, |(small_m & shift_mask)};
    end
  end

  // ---------------- normalize / round helpers ----------------
  logic [9:0]  norm_exp;
  logic        rnd_inc;
  logic        rnd_ovf;
  logic [22:0] rnd_frac;
  logic [9:0]  rnd_exp;

  // RNE on {hidden, frac, G, R, S}; mant[26] is always set when rounding
  always_comb begin
    norm_exp = exp_w - 10'd1;
    rnd_inc  = mant[2] & (mant[1] | mant[0] | mant[3]);
    // an all-ones fraction that increments wraps to 0 and bumps the exponent
    rnd_ovf  = (&mant[25:3]) & rnd_inc;
    rnd_frac = mant[25:3] + {22'd0, rnd_inc};
    rnd_exp  = exp_w + {9'd0, rnd_ovf};
  end

  // ALU opcode is fixed: the ALU's sign-magnitude add handles both ADD and SUB
  assign alu_op = 2'b00;

  // sequencer: single-state-register FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      fp_result  <= 32'd0;
      flags      <= 4'd0;
      alu_en     <= 1'b0;
      alu_a      <= 27'd0;
      alu_b      <= 27'd0;
      alu_sign_a <= 1'b0;
      alu_sign_b <= 1'b0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      op_q       <= 2'd0;
      sa         <= 1'b0;
      sb         <= 1'b0;
      ea         <= 8'd0;
      eb         <= 8'd0;
      ma         <= 27'd0;
      mb         <= 27'd0;
      exp_w      <= 10'd0;
      mant       <= 27'd0;
      sign_r     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= fp_a;
            b_q   <= fp_b;
            op_q  <= op;
            busy  <= 1'b1;
            state <= S_UNPACK;
          end
        end

        S_UNPACK: begin
          sa <= ua_sign;
          sb <= ub_sign;
          ea <= ua_exp;
          eb <= ub_exp;
          ma <= {1'b1, ua_frac, 3'b000};
          mb <= {1'b1, ub_frac, 3'b000};
          if (op_q[1]) begin
            fp_result <= 32'd0;
            flags     <= FLG_UNSUPPORTED;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (ua_nan || ub_nan || (ua_inf && ub_inf && (ua_sign != ub_sign))) begin
            fp_result <= QNAN;
            flags     <= FLG_INVALID;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (ua_inf) begin
            // also covers two infinities of the same sign
            fp_result <= {ua_sign, 8'hFF, 23'd0};
            flags     <= 4'd0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (ub_inf) begin
            fp_result <= {ub_sign, 8'hFF, 23'd0};
            flags     <= 4'd0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (ua_zero && ub_zero) begin
            fp_result <= {ua_sign & ub_sign, 31'd0};
            flags     <= 4'd0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (ua_zero) begin
            fp_result <= {ub_sign, b_q[30:0]};
            flags     <= 4'd0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (ub_zero) begin
            fp_result <= a_q;
            flags     <= 4'd0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_ALIGN;
          end
        end

        S_ALIGN: begin
          // ALU inputs are registered here so they are valid for EXEC and hold through WAIT
          exp_w      <= {2'b00, exp_max};
          alu_a      <= a_big ? ma : aligned_m;
          alu_b      <= a_big ? aligned_m : mb;
          alu_sign_a <= sa;
          alu_sign_b <= sb;
          alu_en     <= 1'b1;
          state      <= S_EXEC;
        end

        S_EXEC: begin
          alu_en <= 1'b0;
          state  <= S_WAIT;
        end

        S_WAIT: begin
          sign_r <= alu_sign;
          if (alu_carry) begin
            // shift right by one, keeping the dropped bit as sticky
            mant  <= {1'b1, alu_result[26:2], alu_result[1] | alu_result[0]};
            exp_w <= exp_w + 10'd1;
            state <= S_NORM;
          end else if (alu_result == 27'd0) begin
            // exact cancellation always yields +0
            fp_result <= 32'd0;
            flags     <= 4'd0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            mant  <= alu_result;
            state <= S_NORM;
          end
        end

        S_NORM: begin
          if (mant[26]) begin
            state <= S_ROUND;
          end else if (norm_exp == 10'd0) begin
            // no denormal output: flush to signed zero
            fp_result <= {sign_r, 31'd0};
            flags     <= FLG_UNDERFLOW;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            mant  <= {mant[25:0], 1'b0};
            exp_w <= norm_exp;
          end
        end

        S_ROUND: begin
          if (rnd_exp >= 10'd255) begin
            fp_result <= {sign_r, 8'hFF, 23'd0};
            flags     <= FLG_OVERFLOW;
          end else begin
            fp_result <= {sign_r, rnd_exp[7:0], rnd_frac};
            flags     <= 4'd0;
          end
          done  <= 1'b1;
          state <= S_DONE;
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
